// File: rtl/i2c_config_sequencer.sv
// ============================================================================
// Module   : i2c_config_sequencer
// Purpose  : Walks a register-init LUT and issues one I2C_control write per
//            entry. Optional NACK retry is enabled with `define I2C_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_config_sequencer #(
    parameter int         LUT_SIZE   = 16,
    parameter int         IDX_W      = 4,
    parameter logic [7:0] SLAVE_ADDR = 8'h34,
    parameter int         MAX_RETRY  = 3,
    parameter int         WAIT_LIMIT = 255,
    parameter int         AUTO_START = 1
) (
    input  logic             CLOCK,
    input  logic             iRST_N,
    input  logic             iSTART,
    input  logic [15:0]      iLUT_DATA,
    output logic [IDX_W-1:0] oLUT_INDEX,
    output logic [23:0]      oI2C_DATA,
    output logic             oGO,
    output logic             oW_R,
    input  logic             iEND,
    input  logic             iACK,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oERROR
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] S_WAIT_HIGH = 3'd3;
    localparam logic [2:0] S_CHECK     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    localparam int               c_WAIT_W     = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT = c_WAIT_W'(WAIT_LIMIT);
    localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(LUT_SIZE - 1);

    generate
        if (LUT_SIZE < 2 || (2 ** IDX_W) < LUT_SIZE || MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_bad_params
            $error("i2c_config_sequencer: illegal parameter combination");
        end
    endgenerate

    logic [2:0]          r_state;
    logic [IDX_W-1:0]    r_index;
    logic [23:0]         r_data;
    logic                r_go;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic                r_auto_pend;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic w_start;
    logic w_timeout;
    logic w_can_retry;

    // A start pulse is honoured only when no sequence is in flight.
    assign w_start = ((r_state == S_IDLE) && (iSTART || r_auto_pend)) ||
                     (((r_state == S_DONE) || (r_state == S_ERROR)) && iSTART);

    assign w_timeout = (r_wait_cnt >= c_WAIT_LIMIT);

`ifdef I2C_RETRY_EN
    logic [2:0] r_retry;

    assign w_can_retry = (r_retry < 3'(MAX_RETRY));

    always_ff @(posedge CLOCK) begin
        if (iRST_N) begin
            r_retry <= 3'd0;
        end else if (w_start) begin
            r_retry <= 3'd0;
        end else if (r_state == S_CHECK) begin
            if (!iACK) begin
                r_retry <= 3'd0;
            end else if (w_can_retry) begin
                r_retry <= r_retry + 3'd1;
            end
        end
    end
`else
    assign w_can_retry = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (iRST_N) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_data      <= 24'd0;
            r_go        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wait_cnt  <= '0;
            r_auto_pend <= (AUTO_START != 0);
        end else if (w_start) begin
            r_state     <= S_LOAD;
            r_index     <= '0;
            r_go        <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_auto_pend <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    // LUT output already reflects the index set on entry.
                    r_data     <= {SLAVE_ADDR, iLUT_DATA};
                    r_state    <= S_WAIT_LOW;
                    r_go       <= 1'b1;
                    r_wait_cnt <= '0;
                end
                S_WAIT_LOW: begin
                    if (!iEND) begin
                        r_state    <= S_WAIT_HIGH;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_ERROR;
                        r_go    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (iEND) begin
                        r_state <= S_CHECK;
                        r_go    <= 1'b0;
                    end else if (w_timeout) begin
                        r_state <= S_ERROR;
                        r_go    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (!iACK) begin
                        if (r_index == c_LAST_IDX) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_index <= r_index + IDX_W'(1);
                            r_state <= S_LOAD;
                        end
                    end else if (w_can_retry) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_ERROR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end
                end
                S_IDLE, S_DONE, S_ERROR: begin
                    r_go <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_go    <= 1'b0;
                end
            endcase
        end
    end

    assign oLUT_INDEX = r_index;
    assign oI2C_DATA  = r_data;
    assign oGO        = r_go;
    assign oW_R       = 1'b0;
    assign oBUSY      = r_busy;
    assign oDONE      = r_done;
    assign oERROR     = r_error;

endmodule

`default_nettype wire

// File: doc/i2c_config_sequencer.md
Name: i2c_config_sequencer

Overview:
- Upstream driver for the I2C_control 24-bit write engine.
- Walks an external register-init lookup table (sub-address plus data per entry) and issues one I2C write per entry.
- Drives the engine's data/GO/W_R inputs, tracks its END/ACK outputs, retries NACKed writes and reports done/error.
- Sits between the board-level codec/sensor init logic and the I2C_control instance, on the same CLOCK.

Parameters:
- LUT_SIZE, 16: number of table entries; minimum 2.
- IDX_W, 4: index width; must satisfy 2^IDX_W >= LUT_SIZE.
- SLAVE_ADDR, 8'h34: 8-bit write address placed in I2C_DATA[23:16].
- MAX_RETRY, 3: extra attempts after a NACK; range 0..7.
- WAIT_LIMIT, 255: CLOCK cycles allowed in each wait state before timeout.
- AUTO_START, 1: when 1, start a sequence automatically after reset release.

Ports:
- CLOCK  in  1  system/I2C control clock; all logic on rising edge.
- iRST_N  in  1  reset; synchronous, active-high (1 = reset), despite the name.
- iSTART  in  1  one-cycle pulse; start or restart the sequence from index 0.
- iLUT_DATA  in  16  table entry {sub_addr[15:8], data[7:0]} for oLUT_INDEX; combinational ROM, valid the cycle after the index changes.
- oLUT_INDEX  out  IDX_W  current table index.
- oI2C_DATA  out  24  {SLAVE_ADDR, latched iLUT_DATA}; goes to I2C_control I2C_DATA.
- oGO  out  1  goes to I2C_control GO.
- oW_R  out  1  constant 0 (write).
- iEND  in  1  from I2C_control END.
- iACK  in  1  from I2C_control ACK; 1 = NACK seen.
- oBUSY  out  1  sequence in progress.
- oDONE  out  1  all entries written; sticky until restart.
- oERROR  out  1  abort; sticky until restart; oLUT_INDEX freezes at the failing entry.

Behaviour:
- Reset values: oGO=0, oLUT_INDEX=0, oI2C_DATA=0, oBUSY=0, oDONE=0, oERROR=0, retry count 0, state IDLE. Reset mid-transfer drops oGO the same edge; the engine is abandoned.
- States: IDLE, LOAD, WAIT_LOW, WAIT_HIGH, CHECK, DONE, ERROR.
- IDLE: oGO=0. Go to LOAD on iSTART, or on the first cycle after reset if AUTO_START=1. On that transition clear the index, retry count and flags, and set oBUSY=1.
- LOAD (1 cycle): oGO=0. Latch oI2C_DATA <= {SLAVE_ADDR, iLUT_DATA}. Next state is WAIT_LOW. The oGO=0 cycle here guarantees the engine counter restarts.
- WAIT_LOW: oGO=1. Wait for iEND==0 (transfer accepted), then go to WAIT_HIGH.
- WAIT_HIGH: oGO=1. Wait for iEND==1 (stop issued), then go to CHECK.
- Timeout: a cycle counter resets on entering WAIT_LOW and WAIT_HIGH. Exceeding WAIT_LIMIT in either state goes to ERROR.
- CHECK (1 cycle): oGO=0. Sample iACK.
  - iACK=0 and index==LUT_SIZE-1: go to DONE.
  - iACK=0 otherwise: index+1, retry count cleared, go to LOAD.
  - iACK=1 and retry count < MAX_RETRY: retry count+1, same index, go to LOAD.
  - iACK=1 otherwise: go to ERROR.
- Minimum per-entry latency: LOAD(1) + WAIT_LOW(≥2) + WAIT_HIGH(≈33) + CHECK(1) cycles.
- DONE: oDONE=1, oBUSY=0, oGO=0. iSTART restarts the sequence (same as from IDLE).
- ERROR: oERROR=1, oBUSY=0, oGO=0, index held. iSTART restarts the sequence.
- iSTART while oBUSY=1 is ignored.
- Index never wraps; the last entry goes to DONE, never back to 0.
- oGO toggles only at the LOAD and CHECK boundaries; no glitches (registered output).

Optional Feature:
- Macro: I2C_RETRY_EN.
- Defined: NACK retry as described, up to MAX_RETRY extra attempts per entry.
- Undefined: retry counter not synthesized; any NACK in CHECK goes straight to ERROR; MAX_RETRY ignored.

Test Plan:
- LUT_SIZE=4, entries 16'h0A01,16'h0B02,16'h0C03,16'h0D04, engine model always ACKs → four writes with oI2C_DATA 24'h340A01..24'h340D04 in order; oDONE=1, oERROR=0, oGO=0 in 4 CHECK passes.
- I2C_RETRY_EN defined, model NACKs index 2 once → index 2 written twice, then index 3; oDONE=1, oERROR=0.
- I2C_RETRY_EN defined, MAX_RETRY=3, index 1 always NACKs → exactly 4 attempts on index 1, then oERROR=1, oLUT_INDEX=1, oDONE=0; without the macro → 1 attempt, then ERROR.
- Model holds iEND=1 forever, WAIT_LIMIT=255 → ERROR 256 cycles after entering WAIT_LOW, oGO=0 afterwards.
- iRST_N=1 asserted during WAIT_HIGH of index 2 → next edge oGO=0, index 0, flags 0; with AUTO_START=1 the sequence reruns from index 0 after release.
- After DONE, pulse iSTART → flags cleared, oBUSY=1, rerun from index 0; iSTART pulsed mid-run → ignored, sequence unchanged.
